control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Hardwired Moore FSM that drives the datapath/memory control inputs of the system block (the drive side of its control interface).
//  Sequences fetch (PC->MAR, memory read, MDR->IR), decodes IR[31:27], and runs per-instruction execute steps.
//  Instruction fields: Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]. The datapath sign-extends C=IR[18:0] onto the bus via c_read.
// PARAMETERS
//  CLEAR_CYCLES   1  cycles out_reg_clear stays high after reset release (>=1)
//  ILLEGAL_HALTS  0  1: an unsupported opcode enters HALT; 0: it is treated as nop
// PORTS
//  clk                      in   1   rising-edge clock
//  in_reset                 in   1   asynchronous, active-high reset
//  in_ir                    in   32  IR contents from the datapath
//  in_stall                 in   1   1 = freeze FSM this cycle
//  out_regfile_location     out  4   register select (Ra/Rb/Rc per step)
//  out_alu_opcode           out  4   add0 sub1 and2 or3 shr4 shl5 ror6 rol7 mul8 div9 neg10 not11
//  out_reg_clear            out  1   clears datapath registers
//  out_mdr_select, out_inc_pc   out 1 each  (mdr_select 1 = MDR loads from memory)
//  out_{regfile,hi,lo,z_hi,z_lo,pc,mdr,inport,c,mem}_read   out  1 each  bus drivers / memory read enable
//  out_{regfile,hi,lo,z,pc,mdr,ir,y,mar,mem}_write          out  1 each  register / memory write enables
//  out_halted               out  1   high in HALT
//  out_illegal              out  1   one-cycle pulse in E0 when the opcode is unsupported
// BEHAVIOUR
//  States: RESET, F0-F3, E0-E5, HALT. Outputs decode combinationally from state and in_ir.
//  Any signal not listed for a step is 0.
//  Reset: in_reset=1 forces RESET asynchronously.
//   In RESET, out_reg_clear=1 and every other output is 0.
//   After release, out_reg_clear stays high for CLEAR_CYCLES clock edges, then the FSM moves to F0. in_stall is ignored in RESET.
//  Fetch:
//   F0: pc_read, mar_write, inc_pc, pc_write.
//   F1: mem_read (memory has 1-cycle registered latency).
//   F2: mdr_select, mdr_write.
//   F3: mdr_read, ir_write.
//   in_ir is valid from E0.
//  Execute (opcode: steps; last step returns to F0):
//   add..rol 00011-01010: E0 loc=Rb regfile_read y_write; E1 loc=Rc regfile_read alu=op z_write; E2 z_lo_read loc=Ra regfile_write.
//   addi/andi/ori 01011-01101, ldi 00001 (ADD): E0 loc=Rb regfile_read y_write; E1 c_read alu=op z_write; E2 z_lo_read loc=Ra regfile_write.
//   ld 00000:
//    E0 Rb->Y
//    E1 c_read ADD z_write
//    E2 z_lo_read mar_write
//    E3 mem_read
//    E4 mdr_select mdr_write
//    E5 mdr_read loc=Ra regfile_write
//   st 00010:
//    E0-E2 as ld
//    E3 loc=Ra regfile_read mdr_write (mdr_select=0)
//    E4 mem_write
//   mul/div 01110/01111:
//    E0 loc=Ra regfile_read y_write
//    E1 loc=Rb regfile_read alu=op z_write
//    E2 z_lo_read lo_write
//    E3 z_hi_read hi_write
//   neg/not 10000/10001: E0 loc=Rb regfile_read alu=op z_write; E1 z_lo_read loc=Ra regfile_write.
//   mfhi 10111 / mflo 11000: E0 hi_read|lo_read, loc=Ra regfile_write.
//   nop 11001: E0 with no outputs asserted.
//   halt 11010: HALT, out_halted=1, all enables 0 until reset.
//   Other opcodes (br, jr, jal, in, out, 11011-11111): E0 with out_illegal=1, then F0 (or HALT if ILLEGAL_HALTS=1).
//  Stall: in_stall=1 holds state and forces all enables and out_inc_pc to 0.
//   On release the step replays in full. Writes, inc_pc and mem_write never fire twice.
//  Reset mid-instruction aborts immediately, with no partial write in the reset cycle.
// TESTING
//  Reset release (CLEAR_CYCLES=1):
//   reg_clear high for 1 cycle.
//   F0: pc_read/mar_write/inc_pc/pc_write; F1: mem_read; F2: mdr_select/mdr_write; F3: mdr_read/ir_write.
//  add R1,R2,R3 (in_ir=0x18918000):
//   E0 loc=2 y_write; E1 loc=3 alu=0 z_write; E2 loc=1 z_lo_read regfile_write.
//   F0 follows, 7 cycles total.
//  ld R4,0x65(R2) (0x02100065):
//   10 cycles total; mem_read in F1 and E3 only; E5 loc=4 regfile_write; mem_write never.
//  st 0x1F(R3),R5 (0x1298001F):
//   E3 loc=5 mdr_write with mdr_select=0; mem_write for exactly one cycle (E4).
//  mul R6,R7 (0x73380000):
//   E0 loc=6; E1 loc=7 alu=8; E2 lo_write; E3 hi_write.
//   Stall held 3 cycles in E1: z_write fires once on release.
//  halt (0xD0000000): out_halted=1, no enables for 20 cycles.
//   Async in_reset mid-ld (E3): outputs drop immediately, reg_clear=1, refetch from F0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore FSM sequencing fetch, decode and execute steps for the
// datapath. Outputs decode combinationally from state, IR and stall.
module control_unit #(
    parameter int CLEAR_CYCLES  = 1,
    parameter bit ILLEGAL_HALTS = 1'b0
) (
    input  logic        clk,
    input  logic        in_reset,
    input  logic [31:0] in_ir,
    input  logic        in_stall,
    output logic [3:0]  out_regfile_location,
    output logic [3:0]  out_alu_opcode,
    output logic        out_reg_clear,
    output logic        out_mdr_select,
    output logic        out_inc_pc,
    output logic        out_regfile_read,
    output logic        out_hi_read,
    output logic        out_lo_read,
    output logic        out_z_hi_read,
    output logic        out_z_lo_read,
    output logic        out_pc_read,
    output logic        out_mdr_read,
    output logic        out_inport_read,
    output logic        out_c_read,
    output logic        out_mem_read,
    output logic        out_regfile_write,
    output logic        out_hi_write,
    output logic        out_lo_write,
    output logic        out_z_write,
    output logic        out_pc_write,
    output logic        out_mdr_write,
    output logic        out_ir_write,
    output logic        out_y_write,
    output logic        out_mar_write,
    output logic        out_mem_write,
    output logic        out_halted,
    output logic        out_illegal
);
    typedef enum logic [3:0] {
        S_RESET, S_F0, S_F1, S_F2, S_F3, S_E0, S_E1, S_E2, S_E3, S_E4, S_E5, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3, C_IMM, C_LD, C_ST, C_MULDIV, C_UNARY, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
    } cls_t;

    localparam int CNT_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
    cls_t             cls;
    logic [3:0]       alu_op;
    logic [4:0]       opcode;
    logic [3:0]       ra, rb, rc;
    logic             frozen;
    logic             unused_ir;

    assign opcode    = in_ir[31:27];
    assign ra        = in_ir[26:23];
    assign rb        = in_ir[22:19];
    assign rc        = in_ir[18:15];
    assign unused_ir = ^in_ir[14:0];
    assign frozen    = in_stall && (state_q != S_RESET) && (state_q != S_HALT);

    always_comb begin
        cls    = C_ILL;
        alu_op = 4'd0;
        case (opcode)
            5'b00000: cls = C_LD;
            5'b00001: cls = C_IMM;
            5'b00010: cls = C_ST;
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
                cls    = C_ALU3;
                alu_op = opcode[3:0] - 4'd3;
            end
            5'b01011: cls = C_IMM;
            5'b01100: begin cls = C_IMM;    alu_op = 4'd2;  end
            5'b01101: begin cls = C_IMM;    alu_op = 4'd3;  end
            5'b01110: begin cls = C_MULDIV; alu_op = 4'd8;  end
            5'b01111: begin cls = C_MULDIV; alu_op = 4'd9;  end
            5'b10000: begin cls = C_UNARY;  alu_op = 4'd10; end
            5'b10001: begin cls = C_UNARY;  alu_op = 4'd11; end
            5'b10111: cls = C_MFHI;
            5'b11000: cls = C_MFLO;
            5'b11001: cls = C_NOP;
            5'b11010: cls = C_HALT;
            default:  cls = C_ILL;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            S_RESET: begin
                if (clr_cnt_q == CNT_W'(CLEAR_CYCLES - 1)) state_d = S_F0;
                else clr_cnt_d = clr_cnt_q + 1'b1;
            end
            S_F0: state_d = S_F1;
            S_F1: state_d = S_F2;
            S_F2: state_d = S_F3;
            S_F3: state_d = S_E0;
            S_E0: begin
                case (cls)
                    C_HALT:                 state_d = S_HALT;
                    C_ILL:                  state_d = ILLEGAL_HALTS ? S_HALT : S_F0;
                    C_MFHI, C_MFLO, C_NOP:  state_d = S_F0;
                    default:                state_d = S_E1;
                endcase
            end
            S_E1: state_d = (cls == C_UNARY) ? S_F0 : S_E2;
            S_E2: state_d = (cls == C_ALU3 || cls == C_IMM) ? S_F0 : S_E3;
            S_E3: state_d = (cls == C_MULDIV) ? S_F0 : S_E4;
            S_E4: state_d = (cls == C_ST) ? S_F0 : S_E5;
            S_E5: state_d = S_F0;
            default: state_d = S_HALT;
        endcase
        // A stalled step is held so it replays in full once released.
        if (frozen) state_d = state_q;
    end

    always_ff @(posedge clk or posedge in_reset) begin
        if (in_reset) begin
            state_q   <= S_RESET;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        out_regfile_location = 4'd0;
        out_alu_opcode       = 4'd0;
        out_reg_clear        = 1'b0;
        out_mdr_select       = 1'b0;
        out_inc_pc           = 1'b0;
        out_regfile_read     = 1'b0;
        out_hi_read          = 1'b0;
        out_lo_read          = 1'b0;
        out_z_hi_read        = 1'b0;
        out_z_lo_read        = 1'b0;
        out_pc_read          = 1'b0;
        out_mdr_read         = 1'b0;
        out_inport_read      = 1'b0;
        out_c_read           = 1'b0;
        out_mem_read         = 1'b0;
        out_regfile_write    = 1'b0;
        out_hi_write         = 1'b0;
        out_lo_write         = 1'b0;
        out_z_write          = 1'b0;
        out_pc_write         = 1'b0;
        out_mdr_write        = 1'b0;
        out_ir_write         = 1'b0;
        out_y_write          = 1'b0;
        out_mar_write        = 1'b0;
        out_mem_write        = 1'b0;
        out_halted           = 1'b0;
        out_illegal          = 1'b0;
        case (state_q)
            S_RESET: out_reg_clear = 1'b1;
            S_F0: begin
                out_pc_read = 1'b1; out_mar_write = 1'b1; out_inc_pc = 1'b1; out_pc_write = 1'b1;
            end
            S_F1: out_mem_read = 1'b1;
            S_F2: begin out_mdr_select = 1'b1; out_mdr_write = 1'b1; end
            S_F3: begin out_mdr_read = 1'b1; out_ir_write = 1'b1; end
            S_E0: begin
                case (cls)
                    C_ALU3, C_IMM, C_LD, C_ST: begin
                        out_regfile_location = rb; out_regfile_read = 1'b1; out_y_write = 1'b1;
                    end
                    C_MULDIV: begin
                        out_regfile_location = ra; out_regfile_read = 1'b1; out_y_write = 1'b1;
                    end
                    C_UNARY: begin
                        out_regfile_location = rb; out_regfile_read = 1'b1;
                        out_alu_opcode = alu_op; out_z_write = 1'b1;
                    end
                    C_MFHI: begin out_hi_read = 1'b1; out_regfile_location = ra; out_regfile_write = 1'b1; end
                    C_MFLO: begin out_lo_read = 1'b1; out_regfile_location = ra; out_regfile_write = 1'b1; end
                    C_ILL:  out_illegal = 1'b1;
                    default: ;
                endcase
            end
            S_E1: begin
                case (cls)
                    C_ALU3: begin
                        out_regfile_location = rc; out_regfile_read = 1'b1;
                        out_alu_opcode = alu_op; out_z_write = 1'b1;
                    end
                    C_IMM, C_LD, C_ST: begin
                        out_c_read = 1'b1; out_alu_opcode = alu_op; out_z_write = 1'b1;
                    end
                    C_MULDIV: begin
                        out_regfile_location = rb; out_regfile_read = 1'b1;
                        out_alu_opcode = alu_op; out_z_write = 1'b1;
                    end
                    C_UNARY: begin
                        out_z_lo_read = 1'b1; out_regfile_location = ra; out_regfile_write = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_E2: begin
                case (cls)
                    C_ALU3, C_IMM: begin
                        out_z_lo_read = 1'b1; out_regfile_location = ra; out_regfile_write = 1'b1;
                    end
                    C_LD, C_ST: begin out_z_lo_read = 1'b1; out_mar_write = 1'b1; end
                    C_MULDIV:   begin out_z_lo_read = 1'b1; out_lo_write = 1'b1; end
                    default: ;
                endcase
            end
            S_E3: begin
                case (cls)
                    C_LD: out_mem_read = 1'b1;
                    C_ST: begin
                        out_regfile_location = ra; out_regfile_read = 1'b1; out_mdr_write = 1'b1;
                    end
                    C_MULDIV: begin out_z_hi_read = 1'b1; out_hi_write = 1'b1; end
                    default: ;
                endcase
            end
            S_E4: begin
                if (cls == C_LD) begin out_mdr_select = 1'b1; out_mdr_write = 1'b1; end
                else if (cls == C_ST) out_mem_write = 1'b1;
            end
            S_E5: begin
                out_mdr_read = 1'b1; out_regfile_location = ra; out_regfile_write = 1'b1;
            end
            default: out_halted = 1'b1;
        endcase
        // While stalled only the selects stay visible; no driver or write may fire.
        if (frozen) begin
            out_mdr_select    = 1'b0;
            out_inc_pc        = 1'b0;
            out_regfile_read  = 1'b0;
            out_hi_read       = 1'b0;
            out_lo_read       = 1'b0;
            out_z_hi_read     = 1'b0;
            out_z_lo_read     = 1'b0;
            out_pc_read       = 1'b0;
            out_mdr_read      = 1'b0;
            out_c_read        = 1'b0;
            out_mem_read      = 1'b0;
            out_regfile_write = 1'b0;
            out_hi_write      = 1'b0;
            out_lo_write      = 1'b0;
            out_z_write       = 1'b0;
            out_pc_write      = 1'b0;
            out_mdr_write     = 1'b0;
            out_ir_write      = 1'b0;
            out_y_write       = 1'b0;
            out_mar_write     = 1'b0;
            out_mem_write     = 1'b0;
            out_illegal       = 1'b0;
        end
    end
endmodule
